block_minmax_mem: RTL and testbench

- Parametrised per-block min/max statistics memory for the motion detector: one {max, min} entry per image block.
- Replaces fixed 4-bit/4800-entry storage with configurable width and depth.
- Adds in-memory merge updates (running max/min), a hardware clear sweep, and a "changed" indication.
- Sits between the block-reduction stage (writer) and the frame-comparison stage (two readers).

---
 rtl/block_minmax_mem_pkg.sv | 17 +
 rtl/block_minmax_mem_if.sv | 34 +++
 rtl/block_minmax_mem_bram_2r1w.sv | 49 ++++
 rtl/block_minmax_mem.sv | 155 +++++++++++++++
 tb/tb_block_minmax_mem.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/block_minmax_mem_pkg.sv
// Shared types and constants for the per-block min/max statistics memory.
package block_minmax_mem_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_DEPTH  = 4800;

  // Sweep values: max cleared to zero, min cleared to all-ones (slice to DATA_W)
  localparam int unsigned CLR_MAX     = 0;
  localparam logic [63:0] CLR_MIN_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/block_minmax_mem_if.sv
// Read ports, update request channel and status between the stages and the stats memory.
interface block_minmax_mem_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 13
);
  logic              rea;
  logic [ADDR_W-1:0] addr_read;
  logic [ADDR_W-1:0] addr_read2;
  logic [DATA_W-1:0] dout_max;
  logic [DATA_W-1:0] dout_min;
  logic [DATA_W-1:0] dout_max2;
  logic [DATA_W-1:0] dout_min2;
  logic              req_valid;
  logic              req_ready;
  logic              req_merge;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] din_max;
  logic [DATA_W-1:0] din_min;
  logic              clr_start;
  logic              busy;
  logic              upd_changed;

  modport master (
    output rea, addr_read, addr_read2, req_valid, req_merge, req_addr,
           din_max, din_min, clr_start,
    input  dout_max, dout_min, dout_max2, dout_min2, req_ready, busy, upd_changed
  );

  modport slave (
    input  rea, addr_read, addr_read2, req_valid, req_merge, req_addr,
           din_max, din_min, clr_start,
    output dout_max, dout_min, dout_max2, dout_min2, req_ready, busy, upd_changed
  );
endinterface

// File: rtl/block_minmax_mem_bram_2r1w.sv
// Two synchronous read-first read ports, one write port; out-of-range reads return zero.
module block_minmax_mem_bram_2r1w #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4800,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_a;
  logic             in_b;
  logic             in_w;

  assign in_a = ({1'b0, addr_a} < DEPTH_X);
  assign in_b = ({1'b0, addr_b} < DEPTH_X);
  assign in_w = ({1'b0, waddr}  < DEPTH_X);

  // Storage array write; contents are not reset
  always_ff @(posedge clk) begin
    if (we && in_w) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read data, holds when its enable is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) rdata_a <= in_a ? mem[addr_a] : '0;
      if (re_b) rdata_b <= in_b ? mem[addr_b] : '0;
    end
  end

endmodule

// File: rtl/block_minmax_mem.sv
// Per-block {max,min} statistics memory with merge updates, forwarding and clear sweep.
module block_minmax_mem
  import block_minmax_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rst_n,
  block_minmax_mem_if.slave bus
);

  localparam int unsigned       ENT_W     = 2 * DATA_W;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] CLR_MAX_V = DATA_W'(CLR_MAX);
  localparam logic [DATA_W-1:0] CLR_MIN_V = CLR_MIN_ALL[DATA_W-1:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q;

  logic              s2_valid_q, s2_inrange_q, s2_merge_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic [DATA_W-1:0] s2_dmax_q, s2_dmin_q;
  logic              fwd_hit_q;
  logic [ENT_W-1:0]  fwd_data_q;

  logic              req_ready_q, busy_q, changed_q;

  logic              accept_c, req_inrange_c;
  logic [ENT_W-1:0]  upd_rdata, stored_c, result_c;
  logic [DATA_W-1:0] st_max_c, st_min_c, new_max_c, new_min_c;
  logic              wr_s2_c, changed_c;
  logic              we_c;
  logic [ADDR_W-1:0] wa_c;
  logic [ENT_W-1:0]  wd_c;
  logic [ENT_W-1:0]  rd_a, rd_b, rd_b_unused;

  assign accept_c      = bus.req_valid & req_ready_q;
  assign req_inrange_c = ({1'b0, bus.req_addr} < DEPTH_X);

  // Reader-facing copy: serves ports A and B
  block_minmax_mem_bram_2r1w #(.WIDTH(ENT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram_rd (
    .clk(clk), .rst_n(rst_n),
    .re_a(bus.rea), .addr_a(bus.addr_read),  .rdata_a(rd_a),
    .re_b(bus.rea), .addr_b(bus.addr_read2), .rdata_b(rd_b),
    .we(we_c), .waddr(wa_c), .wdata(wd_c)
  );

  // Mirror copy written identically; supplies the read half of read-modify-write
  block_minmax_mem_bram_2r1w #(.WIDTH(ENT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram_upd (
    .clk(clk), .rst_n(rst_n),
    .re_a(accept_c), .addr_a(bus.req_addr), .rdata_a(upd_rdata),
    .re_b(1'b0), .addr_b('0), .rdata_b(rd_b_unused),
    .we(we_c), .waddr(wa_c), .wdata(wd_c)
  );

  assign bus.dout_max    = rd_a[ENT_W-1:DATA_W];
  assign bus.dout_min    = rd_a[DATA_W-1:0];
  assign bus.dout_max2   = rd_b[ENT_W-1:DATA_W];
  assign bus.dout_min2   = rd_b[DATA_W-1:0];
  assign bus.req_ready   = req_ready_q;
  assign bus.busy        = busy_q;
  assign bus.upd_changed = changed_q;

  // S2 merge/overwrite result, using forwarded data when S1 hit the previous write
  always_comb begin
    stored_c  = fwd_hit_q ? fwd_data_q : upd_rdata;
    st_max_c  = stored_c[ENT_W-1:DATA_W];
    st_min_c  = stored_c[DATA_W-1:0];
    new_max_c = s2_dmax_q;
    new_min_c = s2_dmin_q;
    if (s2_merge_q) begin
      if (st_max_c > s2_dmax_q) new_max_c = st_max_c;
      if (st_min_c < s2_dmin_q) new_min_c = st_min_c;
    end
    result_c  = {new_max_c, new_min_c};
    wr_s2_c   = s2_valid_q & s2_inrange_q;
    changed_c = wr_s2_c & (result_c != stored_c);
  end

  // Next-state logic and write-port steering (sweep owns the port during CLEAR)
  always_comb begin
    state_d = state_q;
    we_c    = 1'b0;
    wa_c    = s2_addr_q;
    wd_c    = result_c;
    case (state_q)
      ST_IDLE:  if (bus.clr_start) state_d = ST_DRAIN;
      ST_DRAIN: if (!s2_valid_q) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (state_q == ST_CLEAR) begin
      we_c = 1'b1;
      wa_c = clr_addr_q;
      wd_c = {CLR_MAX_V, CLR_MIN_V};
    end else if (wr_s2_c) begin
      we_c = 1'b1;
    end
  end

  // FSM state register and sweep address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) begin
        clr_addr_q <= (clr_addr_q == LAST_ADDR) ? '0 : clr_addr_q + ADDR_W'(1);
      end
    end
  end

  // Update pipeline registers and forwarding capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_inrange_q <= 1'b0;
      s2_merge_q   <= 1'b0;
      s2_addr_q    <= '0;
      s2_dmax_q    <= '0;
      s2_dmin_q    <= '0;
      fwd_hit_q    <= 1'b0;
      fwd_data_q   <= '0;
    end else begin
      s2_valid_q <= accept_c;
      if (accept_c) begin
        s2_inrange_q <= req_inrange_c;
        s2_merge_q   <= bus.req_merge;
        s2_addr_q    <= bus.req_addr;
        s2_dmax_q    <= bus.din_max;
        s2_dmin_q    <= bus.din_min;
      end
      fwd_hit_q  <= accept_c & req_inrange_c & wr_s2_c & (bus.req_addr == s2_addr_q);
      fwd_data_q <= result_c;
    end
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      changed_q   <= 1'b0;
    end else begin
      req_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      changed_q   <= changed_c;
    end
  end

endmodule

// File: tb/tb_block_minmax_mem.sv
// Directed plus randomized checks of block_minmax_mem against an array-based model.
module tb_block_minmax_mem;

  localparam int DW    = 4;
  localparam int DEPTH = 4800;
  localparam int AW    = 13;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  block_minmax_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  block_minmax_mem #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int mmax [DEPTH];
  int mmin [DEPTH];
  int q_addr[$], q_merge[$], q_dmax[$], q_dmin[$];
  int pulses_seen, pulses_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rea = 1'b0; bus.addr_read = '0; bus.addr_read2 = '0;
    bus.req_valid = 1'b0; bus.req_merge = 1'b0; bus.req_addr = '0;
    bus.din_max = '0; bus.din_min = '0; bus.clr_start = 1'b0;
  endtask

  task automatic model_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      mmax[i] = 0;
      mmin[i] = 15;
    end
  endtask

  task automatic model_req(input int a, input int m, input int dx, input int dn, output int chg);
    int nx, nn;
    if (a >= DEPTH) begin
      chg = 0;
    end else begin
      nx = (m != 0) ? ((mmax[a] > dx) ? mmax[a] : dx) : dx;
      nn = (m != 0) ? ((mmin[a] < dn) ? mmin[a] : dn) : dn;
      chg = (nx != mmax[a] || nn != mmin[a]) ? 1 : 0;
      mmax[a] = nx;
      mmin[a] = nn;
    end
  endtask

  function automatic int exp_max(input int a);
    return (a < DEPTH) ? mmax[a] : 0;
  endfunction

  function automatic int exp_min(input int a);
    return (a < DEPTH) ? mmin[a] : 0;
  endfunction

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 6000) begin
      tick();
      n++;
    end
  endtask

  task automatic do_read(input int a, input int b, input string tag);
    bus.rea = 1'b1;
    bus.addr_read  = AW'(a);
    bus.addr_read2 = AW'(b);
    tick();
    bus.rea = 1'b0;
    check({tag, "_a_max"}, bus.dout_max,  exp_max(a));
    check({tag, "_a_min"}, bus.dout_min,  exp_min(a));
    check({tag, "_b_max"}, bus.dout_max2, exp_max(b));
    check({tag, "_b_min"}, bus.dout_min2, exp_min(b));
  endtask

  // Streams queued requests one per cycle; changed pulse expected one tick after the next accept
  task automatic run_burst();
    int prev, chg;
    prev = 0;
    pulses_seen = 0;
    pulses_exp = 0;
    for (int i = 0; i < q_addr.size(); i++) begin
      check("req_ready_burst", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_merge = (q_merge[i] != 0);
      bus.req_addr  = AW'(q_addr[i]);
      bus.din_max   = DW'(q_dmax[i]);
      bus.din_min   = DW'(q_dmin[i]);
      model_req(q_addr[i], q_merge[i], q_dmax[i], q_dmin[i], chg);
      tick();
      check("upd_changed_timing", bus.upd_changed, prev);
      pulses_seen += int'(bus.upd_changed);
      pulses_exp  += prev;
      prev = chg;
    end
    bus.req_valid = 1'b0;
    tick();
    check("upd_changed_timing", bus.upd_changed, prev);
    pulses_seen += int'(bus.upd_changed);
    pulses_exp  += prev;
    tick();
    check("upd_changed_idle", bus.upd_changed, 0);
    q_addr.delete(); q_merge.delete(); q_dmax.delete(); q_dmin.delete();
  endtask

  task automatic push_req(input int a, input int m, input int dx, input int dn);
    q_addr.push_back(a); q_merge.push_back(m); q_dmax.push_back(dx); q_dmin.push_back(dn);
  endtask

  initial begin
    int n, ready_bad, ra, rb;

    // Reset and initial sweep
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_dout_max", bus.dout_max, 0);
    check("rst_dout_min2", bus.dout_min2, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_upd_changed", bus.upd_changed, 0);
    rst_n = 1'b1;
    wait_idle(n);
    check("reset_sweep_cycles", n, 4800);
    check("ready_after_sweep", bus.req_ready, 1);
    model_sweep();
    do_read(0, 4799, "post_reset");

    // Overwrite
    push_req(10, 0, 9, 3);
    run_burst();
    check("overwrite_pulses", pulses_seen, 1);
    do_read(10, 11, "overwrite");

    // Back-to-back merges to one address
    push_req(5, 1, 7, 7);
    push_req(5, 1, 12, 4);
    push_req(5, 1, 3, 1);
    run_burst();
    check("merge_pulses", pulses_seen, 3);
    push_req(5, 1, 2, 2);
    run_burst();
    check("merge_nochange_pulses", pulses_seen, 0);
    do_read(5, 10, "merge");
    check("merge_final_max", bus.dout_max, 12);
    check("merge_final_min", bus.dout_min, 1);

    // Random full-throughput bursts on a small address set (forwarding), some out of range
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 8191)) : int'($urandom_range(0, 7));
      push_req(ra, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    run_burst();
    check("random_pulse_count", pulses_seen, pulses_exp);
    for (int i = 0; i < 8; i++) do_read(i, 7 - i, "random_rb");
    for (int i = 0; i < 20; i++) begin
      ra = int'($urandom_range(0, 8191));
      rb = int'($urandom_range(0, 8191));
      do_read(ra, rb, "random_rd");
    end

    // Out-of-range request and read
    push_req(4800, 0, 9, 9);
    run_burst();
    check("oor_pulses", pulses_seen, 0);
    do_read(5000, 4800, "oor");

    // clr_start with a request accepted in the same cycle
    check("clr_ready_before", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_merge = 1'b0; bus.req_addr = AW'(20);
    bus.din_max = DW'(6); bus.din_min = DW'(6); bus.clr_start = 1'b1;
    tick();
    bus.req_valid = 1'b0; bus.clr_start = 1'b0;
    mmax[20] = 6; mmin[20] = 6;
    check("drain_busy", bus.busy, 1);
    check("drain_req_ready", bus.req_ready, 0);
    tick();
    check("drain_writeback_pulse", bus.upd_changed, 1);
    do_read(20, 21, "drain_written");
    n = 0;
    ready_bad = 0;
    while (bus.busy === 1'b1 && n < 6000) begin
      if (bus.req_ready !== 1'b0) ready_bad++;
      tick();
      n++;
    end
    check("clear_ready_low", ready_bad, 0);
    check("clear_sweep_cycles", n, 4800);
    model_sweep();
    do_read(20, 4799, "after_clear");

    // Reset in the middle of a sweep
    do_read(0, 1, "pre_midsweep");
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    repeat (100) tick();
    check("midsweep_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midsweep_rst_dout_min", bus.dout_min, 0);
    check("midsweep_rst_dout_min2", bus.dout_min2, 0);
    check("midsweep_rst_ready", bus.req_ready, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_idle(n);
    check("midsweep_restart_cycles", n, 4800);

    // Reset while an update is in flight
    do_read(0, 1, "pre_midupd");
    bus.req_valid = 1'b1; bus.req_merge = 1'b0; bus.req_addr = AW'(30);
    bus.din_max = DW'(5); bus.din_min = DW'(5);
    tick();
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midupd_rst_dout_min", bus.dout_min, 0);
    check("midupd_rst_changed", bus.upd_changed, 0);
    check("midupd_rst_busy", bus.busy, 1);
    tick();
    check("midupd_no_pulse", bus.upd_changed, 0);
    rst_n = 1'b1;
    wait_idle(n);
    check("midupd_restart_cycles", n, 4800);
    do_read(30, 4799, "after_midupd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
